// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with memory-controller request/done handshake
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_vd,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rd_enable,
  input  logic        mem_ld,
  input  logic        mem_st,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        mc_req,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_len,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vd,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_enable,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] res;
  logic        mem_op;
  logic        is_store;
  logic [2:0]  len_next;
  logic [31:0] load_ext;

  assign mem_op   = mem_ld | mem_st;
  assign is_store = mem_st & ~mem_ld;

  always_comb begin
    len_next = 3'd4;
    case (mem_funct3[1:0])
      2'b00:   len_next = 3'd1;
      2'b01:   len_next = 3'd2;
      default: len_next = 3'd4;
    endcase
  end

  always_comb begin
    load_ext = mc_rdata;
    case (mem_funct3)
      3'b000:  load_ext = {{24{mc_rdata[7]}}, mc_rdata[7:0]};
      3'b001:  load_ext = {{16{mc_rdata[15]}}, mc_rdata[15:0]};
      3'b100:  load_ext = {24'd0, mc_rdata[7:0]};
      3'b101:  load_ext = {16'd0, mc_rdata[15:0]};
      default: load_ext = mc_rdata;
    endcase
  end

  // EX/MEM is held while stalled, so the mem_* inputs stay valid through WAIT and DONE.
  assign stall_req    = ((state == IDLE) && mem_op) || (state == WAIT);
  assign wb_vd        = ((state == DONE) && mem_ld) ? res : mem_vd;
  assign wb_pc        = mem_pc;
  assign wb_rd        = mem_rd;
  assign wb_rd_enable = mem_rd_enable & ~stall_req & ~is_store & (|mem_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mc_req   <= 1'b0;
      mc_wr    <= 1'b0;
      mc_addr  <= 32'd0;
      mc_wdata <= 32'd0;
      mc_len   <= 3'd0;
      res      <= 32'd0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            mc_req   <= 1'b1;
            mc_wr    <= is_store;
            mc_addr  <= mem_addr;
            mc_wdata <= mem_sdata;
            mc_len   <= len_next;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mc_done) begin
            res    <= load_ext;
            mc_req <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
